apb_uart_csr_fifo: RTL and testbench

APB_UART_CSR_FIFO -- requirements
Module: apb_uart_csr_fifo

---
 rtl/apb_uart_csr_fifo.sv | 237 +++++++++++++++++++++++
 tb/tb_apb_uart_csr_fifo.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_csr_fifo.sv
// apb_uart_csr_fifo
// APB register block for a UART. It holds one TX FIFO and one RX FIFO.
// The block runs with zero wait states. An access either takes effect at its
// access-phase edge or is refused with PSLVERR and then changes no state.
//
// Optional feature macro: UART_IRQ_EN
//   defined   -> the IRQ_EN (0x10) and IRQ_STAT (0x14) registers exist and
//                drive a registered irq output.
//   undefined -> irq is tied low, 0x10/0x14 are unmapped, and the sticky
//                flags are cleared by writing 1 to CTRL[6] or CTRL[7].
//
// Ports
//   PCLK, rst                 clock and synchronous active-high reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA -> PRDATA/PREADY/PSLVERR   APB slave port
//   tx_data/tx_valid/tx_ready TX FIFO head handed to the transmitter
//   rx_data/rx_valid/rx_err   received character strobe and framing-error strobe
//   tx_busy/rx_busy           line status from the UART core
//   tx_en/tx_rst/rx_en/rx_rst mirrors of the CTRL bits
//   irq                       interrupt request
module apb_uart_csr_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 8
) (
    input  logic              PCLK,
    input  logic              rst,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              rx_err,
    input  logic              tx_busy,
    input  logic              rx_busy,
    output logic              tx_en,
    output logic              tx_rst,
    output logic              rx_en,
    output logic              rx_rst,
    output logic              irq
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_STAT     = 3'd1;
    localparam logic [2:0] OFF_TXDATA   = 3'd2;
    localparam logic [2:0] OFF_RXDATA   = 3'd3;
`ifdef UART_IRQ_EN
    localparam logic [2:0] OFF_IRQ_EN   = 3'd4;
    localparam logic [2:0] OFF_IRQ_STAT = 3'd5;
`endif

    logic              access, acc_err, acc_ok, wr_ok, rd_ok;
    logic [2:0]        off;
    logic [31:0]       rdata;
    logic [3:0]        ctrl_q;
    logic              ctrl_we;
    logic              rx_ovr_q, rx_ferr_q, ovr_ev, ovr_clr, ferr_clr;

    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  tx_wp, tx_rp, rx_wp, rx_rp;
    logic [CNT_W-1:0]  tx_cnt, rx_cnt;
    logic              tx_empty, tx_full, rx_empty, rx_full;
    logic              tx_push, tx_pop, tx_clear, rx_push, rx_pop, rx_clear;
    logic              unused_apb;

    assign access = PSEL & PENABLE;
    assign off    = PADDR[4:2];
    assign PREADY = access;
    assign unused_apb = ^{PADDR, PWDATA};

    assign tx_empty = (tx_cnt == '0);
    assign tx_full  = (tx_cnt == DEPTH_C);
    assign rx_empty = (rx_cnt == '0);
    assign rx_full  = (rx_cnt == DEPTH_C);
    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_mem[tx_rp];
    assign tx_pop   = tx_valid & tx_ready;

    // Access legality. A TXDATA write into a full FIFO is allowed only when
    // the transmitter pops in the same cycle and so frees a slot.
    always_comb begin
        acc_err = 1'b0;
        case (off)
            OFF_CTRL:     acc_err = 1'b0;
            OFF_STAT:     acc_err = PWRITE;
            OFF_TXDATA:   acc_err = ~PWRITE | (tx_full & ~tx_pop);
            OFF_RXDATA:   acc_err = PWRITE | rx_empty;
`ifdef UART_IRQ_EN
            OFF_IRQ_EN,
            OFF_IRQ_STAT: acc_err = 1'b0;
`endif
            default:      acc_err = 1'b1;
        endcase
    end

    assign PSLVERR = access & acc_err;
    assign acc_ok  = access & ~acc_err;
    assign wr_ok   = acc_ok & PWRITE;
    assign rd_ok   = acc_ok & ~PWRITE;
    assign ctrl_we = wr_ok & (off == OFF_CTRL);

    assign tx_en  = ctrl_q[3];
    assign tx_rst = ctrl_q[2];
    assign rx_rst = ctrl_q[1];
    assign rx_en  = ctrl_q[0];

    // A flush pulse and the FIFO reset bit empty a FIFO at the edge of the
    // CTRL write itself. Neither is stored, so both read back as 0.
    assign tx_clear = tx_rst | (ctrl_we & (PWDATA[4] | PWDATA[2]));
    assign rx_clear = rx_rst | (ctrl_we & (PWDATA[5] | PWDATA[1]));
    assign tx_push  = wr_ok & (off == OFF_TXDATA) & ~tx_clear;
    assign rx_pop   = rd_ok & (off == OFF_RXDATA);
    assign rx_push  = rx_valid & (~rx_full | rx_pop) & ~rx_clear;
    assign ovr_ev   = rx_valid & rx_full & ~rx_pop & ~rx_clear;

    always_ff @(posedge PCLK) begin
        if (rst)          ctrl_q <= '0;
        else if (ctrl_we) ctrl_q <= PWDATA[3:0];
    end

    always_ff @(posedge PCLK) begin
        if (tx_push) tx_mem[tx_wp] <= PWDATA[DATA_W-1:0];
        if (rx_push) rx_mem[rx_wp] <= rx_data;
    end

    always_ff @(posedge PCLK) begin
        if (rst || tx_clear) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PTR_W'(1);
            if (tx_pop)  tx_rp <= tx_rp + PTR_W'(1);
            if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + CNT_W'(1);
            else if (tx_pop && !tx_push) tx_cnt <= tx_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge PCLK) begin
        if (rst || rx_clear) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + PTR_W'(1);
            if (rx_pop)  rx_rp <= rx_rp + PTR_W'(1);
            if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + CNT_W'(1);
            else if (rx_pop && !rx_push) rx_cnt <= rx_cnt - CNT_W'(1);
        end
    end

    // Sticky error flags. A new event wins over a clear in the same cycle.
    always_ff @(posedge PCLK) begin
        if (rst) begin
            rx_ovr_q  <= 1'b0;
            rx_ferr_q <= 1'b0;
        end else begin
            if (ovr_ev)       rx_ovr_q  <= 1'b1;
            else if (ovr_clr) rx_ovr_q  <= 1'b0;
            if (rx_err)        rx_ferr_q <= 1'b1;
            else if (ferr_clr) rx_ferr_q <= 1'b0;
        end
    end

`ifdef UART_IRQ_EN
    logic [3:0] irq_en_q, irq_stat_q, irq_en_nxt, irq_stat_nxt, irq_ev;
    logic       tx_empty_q, rx_empty_q, irq_q, irq_en_we, irq_stat_we;

    assign irq_en_we   = wr_ok & (off == OFF_IRQ_EN);
    assign irq_stat_we = wr_ok & (off == OFF_IRQ_STAT);
    assign ovr_clr     = irq_stat_we & PWDATA[2];
    assign ferr_clr    = irq_stat_we & PWDATA[3];
    assign irq_ev      = {rx_err, ovr_ev, ~rx_empty & rx_empty_q, tx_empty & ~tx_empty_q};

    // irq is built from the next register values. It therefore rises in the
    // cycle after the event and drops in the cycle after the W1C write.
    always_comb begin
        irq_en_nxt   = irq_en_q;
        irq_stat_nxt = irq_stat_q;
        if (irq_en_we)   irq_en_nxt   = PWDATA[3:0];
        if (irq_stat_we) irq_stat_nxt = irq_stat_q & ~PWDATA[3:0];
        irq_stat_nxt = irq_stat_nxt | irq_ev;
    end

    always_ff @(posedge PCLK) begin
        if (rst) begin
            irq_en_q   <= '0;
            irq_stat_q <= '0;
            irq_q      <= 1'b0;
            tx_empty_q <= 1'b1;
            rx_empty_q <= 1'b1;
        end else begin
            irq_en_q   <= irq_en_nxt;
            irq_stat_q <= irq_stat_nxt;
            irq_q      <= |(irq_stat_nxt & irq_en_nxt);
            tx_empty_q <= tx_empty;
            rx_empty_q <= rx_empty;
        end
    end

    assign irq = irq_q;
`else
    assign ovr_clr  = ctrl_we & PWDATA[6];
    assign ferr_clr = ctrl_we & PWDATA[7];
    assign irq      = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL:   rdata[3:0] = ctrl_q;
            OFF_STAT:   rdata = {8'(tx_cnt), 8'(rx_cnt), 8'h00,
                                 rx_ferr_q, rx_ovr_q, rx_full, rx_empty,
                                 rx_busy, tx_full, tx_empty, tx_busy};
            OFF_RXDATA: rdata[DATA_W-1:0] = rx_mem[rx_rp];
`ifdef UART_IRQ_EN
            OFF_IRQ_EN:   rdata[3:0] = irq_en_q;
            OFF_IRQ_STAT: rdata[3:0] = irq_stat_q;
`endif
            default:    rdata = '0;
        endcase
        PRDATA = rd_ok ? rdata : 32'h0;
    end

endmodule

// File: tb/tb_apb_uart_csr_fifo.sv
// tb_apb_uart_csr_fifo
// Directed testbench for apb_uart_csr_fifo with its default parameters
// (8-bit characters, 16-entry FIFOs). Each scenario task drives stimulus and
// compares the results against hand-computed values.
module tb_apb_uart_csr_fifo;

    logic        PCLK = 1'b0;
    logic        rst;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_err, tx_busy, rx_busy;
    logic        tx_en, tx_rst, rx_en, rx_rst, irq;

    int          checks = 0;
    int          errors = 0;
    logic        last_ready;
    logic [31:0] rd;
    logic        err;

    always #5 PCLK = ~PCLK;

    apb_uart_csr_fifo dut (
        .PCLK(PCLK), .rst(rst),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .tx_busy(tx_busy), .rx_busy(rx_busy),
        .tx_en(tx_en), .tx_rst(tx_rst), .rx_en(rx_en), .rx_rst(rx_rst), .irq(irq)
    );

    // Two-cycle APB write. The response is sampled just after the falling edge of the access phase.
    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data, output logic slverr);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        slverr = PSLVERR;
        last_ready = PREADY;
        @(posedge PCLK);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] addr, output logic [31:0] data, output logic slverr);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        data = PRDATA;
        slverr = PSLVERR;
        last_ready = PREADY;
        @(posedge PCLK);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic pulse_rx(input logic [7:0] d);
        @(negedge PCLK);
        rx_valid = 1'b1; rx_data = d;
        @(negedge PCLK);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_rx_err();
        @(negedge PCLK);
        rx_err = 1'b1;
        @(negedge PCLK);
        rx_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        rst = 1'b0;
        #1;
        checks++;
        if ({tx_valid, tx_en, tx_rst, rx_en, rx_rst, irq} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected 000000", {tx_valid, tx_en, tx_rst, rx_en, rx_rst, irq});
        end
        checks++;
        if ({PREADY, PSLVERR, PRDATA} !== 34'h0) begin
            errors++;
            $display("[TB] FAIL reset_idle_apb: got ready=%b err=%b rdata=%h expected 0", PREADY, PSLVERR, PRDATA);
        end
        apb_read(8'h04, rd, err);
        checks++;
        if (rd !== 32'h0000_0012 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_stat: got %h err=%b expected 00000012 err=0", rd, err);
        end
    endtask

    task automatic test_ctrl();
        apb_write(8'h00, 32'h9, err);
        checks++;
        if (err !== 1'b0 || last_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ctrl_write_resp: got err=%b ready=%b expected err=0 ready=1", err, last_ready);
        end
        checks++;
        if ({tx_en, tx_rst, rx_rst, rx_en} !== 4'b1001) begin
            errors++;
            $display("[TB] FAIL ctrl_mirror: got %b expected 1001", {tx_en, tx_rst, rx_rst, rx_en});
        end
        apb_read(8'h00, rd, err);
        checks++;
        if (rd !== 32'h9 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ctrl_read: got %h err=%b expected 00000009 err=0", rd, err);
        end
        tx_busy = 1'b1; rx_busy = 1'b1;
        apb_read(8'h04, rd, err);
        tx_busy = 1'b0; rx_busy = 1'b0;
        checks++;
        if (rd !== 32'h0000_001B) begin
            errors++;
            $display("[TB] FAIL stat_busy: got %h expected 0000001b", rd);
        end
    endtask

    task automatic test_tx_single();
        tx_ready = 1'b0;
        apb_write(8'h08, 32'hA5, err);
        checks++;
        if (err !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL tx_push: got err=%b valid=%b data=%h expected 0 1 a5", err, tx_valid, tx_data);
        end
        apb_read(8'h04, rd, err);
        checks++;
        if (rd !== 32'h0100_0010) begin
            errors++;
            $display("[TB] FAIL tx_count1: got %h expected 01000010", rd);
        end
        @(negedge PCLK) tx_ready = 1'b1;
        @(negedge PCLK) tx_ready = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tx_pop: got tx_valid=%b expected 0", tx_valid);
        end
        apb_read(8'h04, rd, err);
        checks++;
        if (rd !== 32'h0000_0012) begin
            errors++;
            $display("[TB] FAIL tx_empty_after_pop: got %h expected 00000012", rd);
        end
        apb_read(8'h08, rd, err);
        checks++;
        if (err !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL txdata_read_err: got err=%b rdata=%h expected 1 00000000", err, rd);
        end
    endtask

    task automatic test_tx_overflow();
        logic e17;
        int   bad_pushes;
        bad_pushes = 0;
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            apb_write(8'h08, 32'h10 + i, err);
            if (err !== 1'b0) bad_pushes++;
        end
        checks++;
        if (bad_pushes != 0) begin
            errors++;
            $display("[TB] FAIL tx_fill_resp: got %0d erroring pushes expected 0", bad_pushes);
        end
        apb_write(8'h08, 32'h20, e17);
        checks++;
        if (e17 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tx_overflow_err: got %b expected 1", e17);
        end
        apb_read(8'h04, rd, err);
        checks++;
        if (rd !== 32'h1000_0014) begin
            errors++;
            $display("[TB] FAIL tx_count16: got %h expected 10000014", rd);
        end
    endtask

    // The TX FIFO is full here: a write and a transmitter pop in the same access phase.
    task automatic test_back_to_back();
        logic [7:0] exp_q [16];
        logic [7:0] head;
        for (int i = 0; i < 15; i++) exp_q[i] = 8'h11 + 8'(i);
        exp_q[15] = 8'h99;
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h08; PWDATA = 32'h99;
        @(negedge PCLK);
        PENABLE = 1'b1; tx_ready = 1'b1;
        #1;
        err = PSLVERR;
        head = tx_data;
        @(posedge PCLK);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; tx_ready = 1'b0;
        checks++;
        if (err !== 1'b0 || head !== 8'h10) begin
            errors++;
            $display("[TB] FAIL full_push_pop: got err=%b head=%h expected 0 10", err, head);
        end
        apb_read(8'h04, rd, err);
        checks++;
        if (rd[31:24] !== 8'd16) begin
            errors++;
            $display("[TB] FAIL full_push_pop_count: got %0d expected 16", rd[31:24]);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge PCLK);
            tx_ready = 1'b1;
            #1;
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL tx_order[%0d]: got valid=%b data=%h expected 1 %h", i, tx_valid, tx_data, exp_q[i]);
            end
        end
        @(negedge PCLK);
        tx_ready = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tx_drained: got tx_valid=%b expected 0", tx_valid);
        end
    endtask

    task automatic test_rx_overrun();
        int bad_reads;
        bad_reads = 0;
        for (int i = 0; i < 17; i++) pulse_rx(8'(i));
        apb_read(8'h04, rd, err);
        checks++;
        if (rd !== 32'h0010_0062) begin
            errors++;
            $display("[TB] FAIL rx_full_overrun: got %h expected 00100062", rd);
        end
        for (int i = 0; i < 16; i++) begin
            apb_read(8'h0C, rd, err);
            if (rd !== 32'(i) || err !== 1'b0) begin
                bad_reads++;
                $display("[TB] FAIL rx_read[%0d]: got %h err=%b expected %h err=0", i, rd, err, 32'(i));
            end
        end
        checks++;
        if (bad_reads != 0) errors++;
        apb_read(8'h0C, rd, err);
        checks++;
        if (err !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rx_empty_read_err: got err=%b rdata=%h expected 1 00000000", err, rd);
        end
        apb_read(8'h04, rd, err);
        checks++;
        if (rd !== 32'h0000_0052) begin
            errors++;
            $display("[TB] FAIL rx_overrun_sticky: got %h expected 00000052", rd);
        end
`ifdef UART_IRQ_EN
        apb_write(8'h14, 32'h4, err);
`else
        apb_write(8'h00, 32'h49, err);
`endif
        apb_read(8'h04, rd, err);
        checks++;
        if (rd !== 32'h0000_0012) begin
            errors++;
            $display("[TB] FAIL rx_overrun_clear: got %h expected 00000012", rd);
        end
    endtask

    task automatic test_rx_simul();
        logic [31:0] got;
        pulse_rx(8'h33);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h0C;
        @(negedge PCLK);
        PENABLE = 1'b1; rx_valid = 1'b1; rx_data = 8'h44;
        #1;
        got = PRDATA;
        err = PSLVERR;
        @(posedge PCLK);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0; rx_valid = 1'b0;
        checks++;
        if (got !== 32'h33 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rx_push_pop_data: got %h err=%b expected 00000033 err=0", got, err);
        end
        apb_read(8'h04, rd, err);
        checks++;
        if (rd !== 32'h0001_0002) begin
            errors++;
            $display("[TB] FAIL rx_push_pop_count: got %h expected 00010002", rd);
        end
        apb_read(8'h0C, rd, err);
        checks++;
        if (rd !== 32'h44) begin
            errors++;
            $display("[TB] FAIL rx_second: got %h expected 00000044", rd);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) apb_write(8'h08, 32'h50 + i, err);
        pulse_rx(8'h61);
        pulse_rx(8'h62);
        apb_read(8'h04, rd, err);
        checks++;
        if (rd !== 32'h0302_0000) begin
            errors++;
            $display("[TB] FAIL pre_flush_stat: got %h expected 03020000", rd);
        end
        apb_write(8'h00, 32'h39, err);
        apb_read(8'h04, rd, err);
        checks++;
        if (rd !== 32'h0000_0012) begin
            errors++;
            $display("[TB] FAIL flush_stat: got %h expected 00000012", rd);
        end
        apb_read(8'h00, rd, err);
        checks++;
        if (rd !== 32'h9) begin
            errors++;
            $display("[TB] FAIL flush_selfclear: got %h expected 00000009", rd);
        end
        apb_write(8'h00, 32'hD, err);
        checks++;
        if (tx_rst !== 1'b1 || rx_rst !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tx_rst_mirror: got tx_rst=%b rx_rst=%b expected 1 0", tx_rst, rx_rst);
        end
        apb_write(8'h08, 32'h77, err);
        apb_read(8'h04, rd, err);
        checks++;
        if (rd !== 32'h0000_0012) begin
            errors++;
            $display("[TB] FAIL tx_rst_holds_empty: got %h expected 00000012", rd);
        end
        apb_write(8'h00, 32'h9, err);
    endtask

    task automatic test_errors();
        apb_write(8'h04, 32'hFFFF_FFFF, err);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stat_write_err: got %b expected 1", err);
        end
        apb_read(8'h04, rd, err);
        checks++;
        if (rd !== 32'h0000_0012) begin
            errors++;
            $display("[TB] FAIL stat_unchanged: got %h expected 00000012", rd);
        end
        apb_write(8'h0C, 32'h1, err);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rxdata_write_err: got %b expected 1", err);
        end
        apb_read(8'h18, rd, err);
        checks++;
        if (err !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL unmapped_read: got err=%b rdata=%h expected 1 00000000", err, rd);
        end
        apb_write(8'h1C, 32'h3, err);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL unmapped_write: got %b expected 1", err);
        end
        apb_read(8'h00, rd, err);
        checks++;
        if (rd !== 32'h9 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ctrl_intact: got %h err=%b expected 00000009 err=0", rd, err);
        end
    endtask

`ifdef UART_IRQ_EN
    task automatic test_irq();
        apb_write(8'h14, 32'hF, err);
        apb_read(8'h14, rd, err);
        checks++;
        if (rd !== 32'h0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_stat_cleared: got %h err=%b expected 0 0", rd, err);
        end
        apb_write(8'h10, 32'h8, err);
        apb_read(8'h10, rd, err);
        checks++;
        if (rd !== 32'h8) begin
            errors++;
            $display("[TB] FAIL irq_en_read: got %h expected 00000008", rd);
        end
        pulse_rx_err();
        #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL irq_rise: got %b expected 1", irq);
        end
        apb_read(8'h04, rd, err);
        checks++;
        if (rd !== 32'h0000_0092) begin
            errors++;
            $display("[TB] FAIL ferr_sticky: got %h expected 00000092", rd);
        end
        apb_write(8'h14, 32'h8, err);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_clear: got %b expected 0", irq);
        end
        apb_read(8'h04, rd, err);
        checks++;
        if (rd !== 32'h0000_0012) begin
            errors++;
            $display("[TB] FAIL ferr_clear: got %h expected 00000012", rd);
        end
    endtask
`else
    task automatic test_sticky_noirq();
        pulse_rx_err();
        apb_read(8'h04, rd, err);
        checks++;
        if (rd !== 32'h0000_0092) begin
            errors++;
            $display("[TB] FAIL ferr_sticky: got %h expected 00000092", rd);
        end
        apb_write(8'h00, 32'h89, err);
        apb_read(8'h04, rd, err);
        checks++;
        if (rd !== 32'h0000_0012) begin
            errors++;
            $display("[TB] FAIL ferr_ctrl_clear: got %h expected 00000012", rd);
        end
        apb_read(8'h10, rd, err);
        checks++;
        if (err !== 1'b1 || irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_regs_unmapped: got err=%b irq=%b expected 1 0", err, irq);
        end
        apb_write(8'h14, 32'hF, err);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL irq_stat_unmapped: got %b expected 1", err);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_err = 1'b0;
        tx_busy = 1'b0; rx_busy = 1'b0; last_ready = 1'b0;
        test_reset();
        test_ctrl();
        test_tx_single();
        test_tx_overflow();
        test_back_to_back();
        test_rx_overrun();
        test_rx_simul();
        test_flush();
        test_errors();
`ifdef UART_IRQ_EN
        test_irq();
`else
        test_sticky_noirq();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
